// File: rtl/vga_timing_if.sv
// Display-control and VGA pin bundle produced by vga_timing_gen.
// The master modport drives the bundle; the slave modport is for the pixel generator and the pins.
interface vga_timing_if;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_screen_reset;
    logic       o_pixel_x_clock;
    logic       o_pixel_y_clock;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_active;
    logic       o_hsync_n;
    logic       o_vsync_n;
    logic       o_de;

    modport master (
        output o_hsync, o_vsync, o_screen_reset, o_pixel_x_clock, o_pixel_y_clock,
        output o_x, o_y, o_active, o_hsync_n, o_vsync_n, o_de
    );

    modport slave (
        input o_hsync, o_vsync, o_screen_reset, o_pixel_x_clock, o_pixel_y_clock,
        input o_x, o_y, o_active, o_hsync_n, o_vsync_n, o_de
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, single-cycle
// pixel-generator strobes and sync/data-enable pins delayed to match the colour pipeline.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int X_DIV      = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int XW      = (X_DIV > 1) ? $clog2(X_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] XSUB_LAST  = XW'(X_DIV - 1);
    localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]    H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]    HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [XW-1:0] xsub_q, xsub_d;
    logic          first_q, first_d;
    logic          pix_en;

    logic       x_clk_q, x_clk_d, y_clk_q, y_clk_d;
    logic       vsync_q, vsync_d, scr_rst_q, scr_rst_d;
    logic       hsync_q, hsync_d, active_q, active_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hs_n_q, hs_n_d, vs_n_q, vs_n_d;

    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;

    always_comb begin
        pix_en  = (div_q == DIV_LAST);
        div_d   = pix_en ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        xsub_d  = xsub_q;
        first_d = 1'b0;

        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            if (h_q < H_ACT) begin
                xsub_d = (xsub_q == XSUB_LAST) ? '0 : xsub_q + 1'b1;
            end
        end
        // Keep the x sub-divider phase-aligned to the start of every active line.
        if (h_q >= H_ACT) begin
            xsub_d = '0;
        end

        x_clk_d   = pix_en && (v_q < V_ACT) && (h_q < H_ACT) && (xsub_q == XSUB_LAST);
        y_clk_d   = pix_en && (h_q == H_ACT_LAST) && (v_q < V_ACT);
        vsync_d   = pix_en && (h_q == H_LAST) && (v_q == V_ACT_LAST);
        // first_q is set during reset so the pixel generator restarts right after release.
        scr_rst_d = first_q || (pix_en && (h_q == H_LAST) && (v_q == V_LAST));

        hsync_d  = (h_q >= H_ACT);
        active_d = (h_q < H_ACT) && (v_q < V_ACT);
        x_d      = h_q;
        y_d      = v_q;
        hs_n_d   = !((h_q >= HS_START) && (h_q < HS_END));
        vs_n_d   = !((v_q >= VS_START) && (v_q < VS_END));
    end

    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        de_pipe_d    = de_pipe_q;
        hs_pipe_d[0] = hs_n_q;
        vs_pipe_d[0] = vs_n_q;
        de_pipe_d[0] = active_q;
        for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
            de_pipe_d[i] = de_pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            xsub_q    <= '0;
            first_q   <= 1'b1;
            x_clk_q   <= 1'b0;
            y_clk_q   <= 1'b0;
            vsync_q   <= 1'b0;
            scr_rst_q <= 1'b0;
            hsync_q   <= 1'b0;
            active_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
            de_pipe_q <= '0;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            xsub_q    <= xsub_d;
            first_q   <= first_d;
            x_clk_q   <= x_clk_d;
            y_clk_q   <= y_clk_d;
            vsync_q   <= vsync_d;
            scr_rst_q <= scr_rst_d;
            hsync_q   <= hsync_d;
            active_q  <= active_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_n_q    <= hs_n_d;
            vs_n_q    <= vs_n_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
        end
    end

    assign vga.o_hsync         = hsync_q;
    assign vga.o_vsync         = vsync_q;
    assign vga.o_screen_reset  = scr_rst_q;
    assign vga.o_pixel_x_clock = x_clk_q;
    assign vga.o_pixel_y_clock = y_clk_q;
    assign vga.o_x             = x_q;
    assign vga.o_y             = y_q;
    assign vga.o_active        = active_q;
    assign vga.o_hsync_n       = hs_pipe_q[PIPE_DELAY-1];
    assign vga.o_vsync_n       = vs_pipe_q[PIPE_DELAY-1];
    assign vga.o_de            = de_pipe_q[PIPE_DELAY-1];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line timing, a tiny-geometry
// instance (12x7 pixel frame, 168 clocks) for whole-frame, vertical and mid-frame reset behaviour.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_def, rst_sm;
    always #5 clk = ~clk;

    vga_timing_if if_def ();
    vga_timing_if if_sm ();

    vga_timing_gen u_def (
        .i_clk   (clk),
        .i_reset (rst_def),
        .vga     (if_def)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .X_DIV(1),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DELAY(1)
    ) u_sm (
        .i_clk   (clk),
        .i_reset (rst_sm),
        .vga     (if_sm)
    );

    // k = cycles since reset release; the rest are expected small-instance outputs at that cycle.
    typedef struct {
        int k; int x; int y; int act; int hsync;
        int xclk; int yclk; int vs; int sr;
        int hs_n; int vs_n; int de;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ti;
    int d_hsn_low, d_hsn_first, d_hsync_hi, d_xclk, d_yclk, d_sr, d_wide;
    int s_xclk, s_yclk, s_vs, s_sr, s_hsn_low, s_vsn_low, s_de_hi, s_sr_all, s_wide;
    logic [3:0] d_prev, s_prev, d_cur, s_cur;

    initial begin
        //        k    x  y act hs  xc yc vs sr hsn vsn de
        tbl[0]  = '{1,   0, 0, 1, 0,  0, 0, 0, 1,  1, 1, 0};
        tbl[1]  = '{2,   0, 0, 1, 0,  1, 0, 0, 0,  1, 1, 1};
        tbl[2]  = '{3,   1, 0, 1, 0,  0, 0, 0, 0,  1, 1, 1};
        tbl[3]  = '{16,  7, 0, 1, 0,  1, 1, 0, 0,  1, 1, 1};
        tbl[4]  = '{17,  8, 0, 0, 1,  0, 0, 0, 0,  1, 1, 1};
        tbl[5]  = '{18,  8, 0, 0, 1,  0, 0, 0, 0,  1, 1, 0};
        tbl[6]  = '{20,  9, 0, 0, 1,  0, 0, 0, 0,  0, 1, 0};
        tbl[7]  = '{23, 11, 0, 0, 1,  0, 0, 0, 0,  0, 1, 0};
        tbl[8]  = '{24, 11, 0, 0, 1,  0, 0, 0, 0,  1, 1, 0};
        tbl[9]  = '{25,  0, 1, 1, 0,  0, 0, 0, 0,  1, 1, 0};
        tbl[10] = '{96, 11, 3, 0, 1,  0, 0, 1, 0,  1, 1, 0};
        tbl[11] = '{97,  0, 4, 0, 0,  0, 0, 0, 0,  1, 1, 0};
        tbl[12] = '{121, 0, 5, 0, 0,  0, 0, 0, 0,  1, 1, 0};
        tbl[13] = '{122, 0, 5, 0, 0,  0, 0, 0, 0,  1, 0, 0};
        tbl[14] = '{168,11, 6, 0, 1,  0, 0, 0, 1,  1, 1, 0};
        tbl[15] = '{169, 0, 0, 1, 0,  0, 0, 0, 0,  1, 1, 0};
        tbl[16] = '{170, 0, 0, 1, 0,  1, 0, 0, 0,  1, 1, 1};

        ti = 0;
        d_hsn_low = 0; d_hsn_first = 0; d_hsync_hi = 0; d_xclk = 0; d_yclk = 0; d_sr = 0; d_wide = 0;
        s_xclk = 0; s_yclk = 0; s_vs = 0; s_sr = 0; s_hsn_low = 0; s_vsn_low = 0; s_de_hi = 0;
        s_sr_all = 0; s_wide = 0;
        d_prev = '0; s_prev = '0;

        rst_def = 1'b1;
        rst_sm  = 1'b1;
        repeat (5) begin
            tick();
            chk("rst_hsync_n", int'(if_def.o_hsync_n), 1);
            chk("rst_vsync_n", int'(if_def.o_vsync_n), 1);
            chk("rst_de", int'(if_def.o_de), 0);
            chk("rst_screen_reset", int'(if_def.o_screen_reset), 0);
        end
        chk("rst_x", int'(if_def.o_x), 0);
        chk("rst_y", int'(if_def.o_y), 0);
        rst_def = 1'b0;
        rst_sm  = 1'b0;

        for (int k = 1; k <= 6400; k++) begin
            tick();
            // Default instance: reset release, one full line of timing (line 1)
            if (k <= 4) begin
                chk($sformatf("post_rst_de k=%0d", k), int'(if_def.o_de), 0);
                chk($sformatf("post_rst_hsync_n k=%0d", k), int'(if_def.o_hsync_n), 1);
                chk($sformatf("post_rst_vsync_n k=%0d", k), int'(if_def.o_vsync_n), 1);
            end
            if (k == 5) chk("de_rise k=5", int'(if_def.o_de), 1);
            if (k <= 8) chk($sformatf("def_sr k=%0d", k), int'(if_def.o_screen_reset), (k == 1) ? 1 : 0);
            if (if_def.o_screen_reset) d_sr++;
            if (k >= 3201) begin
                if (!if_def.o_hsync_n) begin
                    d_hsn_low++;
                    if (d_hsn_first == 0) d_hsn_first = k;
                end
                if (if_def.o_hsync) d_hsync_hi++;
                if (if_def.o_pixel_x_clock) d_xclk++;
                if (if_def.o_pixel_y_clock) d_yclk++;
            end
            d_cur = {if_def.o_pixel_x_clock, if_def.o_pixel_y_clock, if_def.o_vsync, if_def.o_screen_reset};
            if ((d_cur & d_prev) != 4'b0) d_wide++;
            d_prev = d_cur;

            // Small instance: vector table and one-frame totals
            if (ti < NVEC && tbl[ti].k == k) begin
                $display("vec k=%0d x=%0d y=%0d act=%0d xclk=%0d yclk=%0d vs=%0d sr=%0d hs_n=%0d vs_n=%0d de=%0d",
                         k, if_sm.o_x, if_sm.o_y, if_sm.o_active, if_sm.o_pixel_x_clock,
                         if_sm.o_pixel_y_clock, if_sm.o_vsync, if_sm.o_screen_reset,
                         if_sm.o_hsync_n, if_sm.o_vsync_n, if_sm.o_de);
                chk($sformatf("vec%0d x", k),      int'(if_sm.o_x), tbl[ti].x);
                chk($sformatf("vec%0d y", k),      int'(if_sm.o_y), tbl[ti].y);
                chk($sformatf("vec%0d active", k), int'(if_sm.o_active), tbl[ti].act);
                chk($sformatf("vec%0d hsync", k),  int'(if_sm.o_hsync), tbl[ti].hsync);
                chk($sformatf("vec%0d xclk", k),   int'(if_sm.o_pixel_x_clock), tbl[ti].xclk);
                chk($sformatf("vec%0d yclk", k),   int'(if_sm.o_pixel_y_clock), tbl[ti].yclk);
                chk($sformatf("vec%0d vsync", k),  int'(if_sm.o_vsync), tbl[ti].vs);
                chk($sformatf("vec%0d sr", k),     int'(if_sm.o_screen_reset), tbl[ti].sr);
                chk($sformatf("vec%0d hsync_n", k), int'(if_sm.o_hsync_n), tbl[ti].hs_n);
                chk($sformatf("vec%0d vsync_n", k), int'(if_sm.o_vsync_n), tbl[ti].vs_n);
                chk($sformatf("vec%0d de", k),     int'(if_sm.o_de), tbl[ti].de);
                ti++;
            end
            if (k >= 2 && k <= 169) begin
                if (if_sm.o_pixel_x_clock) s_xclk++;
                if (if_sm.o_pixel_y_clock) s_yclk++;
                if (if_sm.o_vsync) s_vs++;
                if (if_sm.o_screen_reset) s_sr++;
                if (!if_sm.o_hsync_n) s_hsn_low++;
                if (!if_sm.o_vsync_n) s_vsn_low++;
                if (if_sm.o_de) s_de_hi++;
            end
            if (k <= 340 && if_sm.o_screen_reset) s_sr_all++;
            if (k == 336) chk("sm_sr second wrap k=336", int'(if_sm.o_screen_reset), 1);
            s_cur = {if_sm.o_pixel_x_clock, if_sm.o_pixel_y_clock, if_sm.o_vsync, if_sm.o_screen_reset};
            if ((s_cur & s_prev) != 4'b0) s_wide++;
            s_prev = s_cur;
        end

        chk("vectors_applied", ti, NVEC);
        chk("def_hsync_n_first_low", d_hsn_first, 5829);
        chk("def_hsync_n_low_clocks", d_hsn_low, 384);
        chk("def_hsync_high_clocks", d_hsync_hi, 640);
        chk("def_xclk_per_line", d_xclk, 320);
        chk("def_yclk_per_line", d_yclk, 1);
        chk("def_sr_count", d_sr, 1);
        chk("def_wide_strobes", d_wide, 0);
        chk("sm_xclk_per_frame", s_xclk, 32);
        chk("sm_yclk_per_frame", s_yclk, 4);
        chk("sm_vsync_per_frame", s_vs, 1);
        chk("sm_sr_per_frame", s_sr, 1);
        chk("sm_hsync_n_low", s_hsn_low, 28);
        chk("sm_vsync_n_low", s_vsn_low, 24);
        chk("sm_de_high", s_de_hi, 64);
        chk("sm_sr_first_340", s_sr_all, 3);
        chk("sm_wide_strobes", s_wide, 0);

        // Mid-frame reset on the small instance at h=5, v=2
        begin
            int n;
            n = 0;
            while (!(if_sm.o_x == 10'd5 && if_sm.o_y == 10'd2) && n < 400) begin
                tick();
                n++;
            end
            chk("mid_rst_wait_in_budget", (n < 400) ? 1 : 0, 1);
        end
        rst_sm = 1'b1;
        repeat (3) tick();
        chk("mid_rst_x", int'(if_sm.o_x), 0);
        chk("mid_rst_y", int'(if_sm.o_y), 0);
        chk("mid_rst_hsync_n", int'(if_sm.o_hsync_n), 1);
        chk("mid_rst_de", int'(if_sm.o_de), 0);
        chk("mid_rst_xclk", int'(if_sm.o_pixel_x_clock), 0);
        rst_sm = 1'b0;
        s_sr_all = 0;
        for (int k = 1; k <= 340; k++) begin
            tick();
            if (if_sm.o_screen_reset) s_sr_all++;
            if (k == 1) begin
                chk("mid_rel_x k=1", int'(if_sm.o_x), 0);
                chk("mid_rel_y k=1", int'(if_sm.o_y), 0);
                chk("mid_rel_sr k=1", int'(if_sm.o_screen_reset), 1);
            end
            if (k == 2) chk("mid_rel_sr k=2", int'(if_sm.o_screen_reset), 0);
            if (k == 5) chk("mid_rel_x k=5", int'(if_sm.o_x), 2);
            if (k == 27) chk("mid_rel_y k=27", int'(if_sm.o_y), 1);
            if (k == 167) chk("mid_rel_sr k=167", int'(if_sm.o_screen_reset), 0);
            if (k == 168) chk("mid_rel_sr k=168", int'(if_sm.o_screen_reset), 1);
            if (k == 336) chk("mid_rel_sr k=336", int'(if_sm.o_screen_reset), 1);
        end
        chk("mid_rel_sr_count", s_sr_all, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA 640x480@60 raster timing generator that drives the display-control inputs of the pixel generator and the VGA sync pins. It derives a pixel tick from `i_clk`, runs horizontal and vertical counters, and emits single-cycle strobes for the pixel generator: x-clock, y-clock, vsync and screen-reset. It also produces a horizontal-blank level. Sync pins and data-enable are delayed to line up with the pixel generator's colour pipeline.

## Interface
- `CLK_DIV`, 4: `i_clk` cycles per VGA pixel (≥2).
- `X_DIV`, 2: VGA pixels per `o_pixel_x_clock` pulse (≥1).
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels; `H_TOTAL` is their sum (800).
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines; `V_TOTAL` is their sum (525).
- `PIPE_DELAY`, 4: `i_clk` cycles of delay applied to `o_hsync_n`, `o_vsync_n` and `o_de`.
- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `o_hsync` out 1: horizontal-blank level, high while h ≥ `H_ACTIVE` (feeds pixel generator `i_hsync`).
- `o_vsync` out 1: one-cycle strobe on entry to vertical blank (feeds `i_vsync`).
- `o_screen_reset` out 1: one-cycle strobe at frame start (feeds `i_screen_reset`).
- `o_pixel_x_clock` out 1: one-cycle strobe, one per `X_DIV` active pixels.
- `o_pixel_y_clock` out 1: one-cycle strobe at the end of each active line.
- `o_x` out 10: current h counter, registered.
- `o_y` out 10: current v counter, registered.
- `o_active` out 1: h < `H_ACTIVE` and v < `V_ACTIVE`, undelayed.
- `o_hsync_n` out 1: VGA HSYNC pin, active low, delayed.
- `o_vsync_n` out 1: VGA VSYNC pin, active low, delayed.
- `o_de` out 1: `o_active` delayed by `PIPE_DELAY`.

## Operation
**Counters**
- `div` counts 0..`CLK_DIV`-1; `pix_en` = (`div` == `CLK_DIV`-1).
- On `pix_en`: `h` increments. At `H_TOTAL`-1, `h` wraps to 0 and `v` increments. At `V_TOTAL`-1, `v` wraps to 0.
- `xsub` counts 0..`X_DIV`-1 on `pix_en` while h < `H_ACTIVE`. It is forced to 0 whenever h ≥ `H_ACTIVE`.

**Strobe conditions** (all evaluated on a `pix_en` cycle, all registered)
- `o_pixel_x_clock`: v < `V_ACTIVE`, h < `H_ACTIVE`, `xsub` == `X_DIV`-1. Gives 320 pulses/line and 153600/frame.
- `o_pixel_y_clock`: h == `H_ACTIVE`-1 and v < `V_ACTIVE`. Gives 480/frame.
- `o_vsync`: h == `H_TOTAL`-1 and v == `V_ACTIVE`-1. Gives 1/frame.
- `o_screen_reset`: h == `H_TOTAL`-1 and v == `V_TOTAL`-1. Also asserted on the first cycle after `i_reset` deasserts.

**Sync pin windows**
- HSYNC low for `H_ACTIVE`+`H_FP` ≤ h < `H_ACTIVE`+`H_FP`+`H_SYNC` (656..751).
- VSYNC low for `V_ACTIVE`+`V_FP` ≤ v < `V_ACTIVE`+`V_FP`+`V_SYNC` (490..491).

**Delay line**
- HSYNC, VSYNC and active pass through a `PIPE_DELAY`-stage shift register that advances every `i_clk` to form `o_hsync_n`, `o_vsync_n` and `o_de`.

**Reset**
- `div`, `h`, `v` and `xsub` go to 0.
- All strobes, `o_hsync`, `o_active`, `o_x` and `o_y` go to 0.
- Every delay stage loads the idle values: sync_n=1, de=0.
- Reset mid-frame aborts immediately; there is no partial-frame completion.

**Simultaneous events**
- At the frame wrap, `o_screen_reset` and `o_pixel_y_clock` never coincide: they are `H_ACTIVE`..`H_TOTAL` pixels apart.
- `o_vsync` and `o_pixel_y_clock` can fall in the same line: the y-clock is at h=639 and the vsync strobe at h=799. Both are emitted.

## Timing
- Registered outputs reflect counter state with 1 `i_clk` latency.
- Strobes are exactly 1 `i_clk` wide, regardless of `CLK_DIV`.
- `o_hsync` changes only on the cycle after a `pix_en`.
- `o_hsync_n`, `o_vsync_n` and `o_de` lag their undelayed equivalents by exactly `PIPE_DELAY` cycles.
- Line period is `H_TOTAL`·`CLK_DIV` = 3200 clocks; frame period is 1,680,000 clocks.
- The first `o_screen_reset` follows reset release by 1 cycle. The next follows it by exactly one frame period.

## Test plan
- **Reset release:** hold `i_reset` 5 cycles, then release. Required: `o_screen_reset`=1 on cycle 1 only; `o_hsync_n`=`o_vsync_n`=1 and `o_de`=0 during reset and for `PIPE_DELAY` cycles after.
- **Full frame, defaults:** count pulses over 1,680,000 clocks. Required: x_clock=153600, y_clock=480, vsync=1, screen_reset=1; every pulse exactly 1 cycle wide.
- **Line timing:** measure `o_hsync_n` within one line. Required: low for 384 clocks, starting 656·4+1+4 = 2629 clocks after the line's h=0 `pix_en`. `o_hsync` is high for 640 clocks per line.
- **Vertical:** required: `o_vsync_n` low for exactly 6400 clocks, on lines 490–491 only. `o_vsync` pulses after the last pixel of line 479.
- **Reset mid-line:** assert `i_reset` at h=300, v=100. Required: on release, `o_x`=0 and `o_y`=0; counting restarts from (0,0); the next screen_reset comes one frame later.
- **Small parameters:** `CLK_DIV`=2, `X_DIV`=1, H=8/1/2/1, V=4/1/1/1, `PIPE_DELAY`=1. Required: 8 x_clocks/line, 4 y_clocks/frame, frame = 12·7·2 = 168 clocks, wrap correct.
